// File: rtl/exec_hazard_ctrl_pkg.sv
// Shared types and constants for the execute-stage hazard scheduler.
// Holds the forwarding select encodings, the scoreboard slot layout and the register index width.
package exec_hazard_ctrl_pkg;

    localparam int unsigned REG_W = 4;

    localparam logic [1:0] SEL_REG = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    localparam int unsigned NUM_SLOTS = 3;
    localparam int unsigned SLOT_EXE  = 0;
    localparam int unsigned SLOT_MEM  = 1;
    localparam int unsigned SLOT_WB   = 2;

    typedef struct packed {
        logic             valid;
        logic             wb_en;
        logic [REG_W-1:0] dest;
        logic             is_load;
    } slot_t;

    // The youngest producer wins: EXE now means MEM next cycle, MEM now means WB next cycle.
    function automatic logic [1:0] fwd_sel(input logic exe_match, input logic mem_match);
        if (exe_match) begin
            return SEL_MEM;
        end
        if (mem_match) begin
            return SEL_WB;
        end
        return SEL_REG;
    endfunction

endpackage

// File: rtl/exec_hazard_ctrl_if.sv
// Bundle between the ID/EXE pipeline control and the hazard scheduler.
// The master side is the pipeline; the slave side is exec_hazard_ctrl.
interface exec_hazard_ctrl_if #(
    parameter int unsigned REG_W = 4
);
    logic             id_valid;
    logic [REG_W-1:0] id_src1;
    logic [REG_W-1:0] id_src2;
    logic             id_two_src;
    logic             id_wb_en;
    logic [REG_W-1:0] id_dest;
    logic             id_mem_r_en;
    logic             br_taken;
    logic             stall;
    logic             flush;
    logic [1:0]       src1_sel;
    logic [1:0]       src2_sel;

    modport master (
        output id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_dest, id_mem_r_en,
        output br_taken,
        input  stall, flush, src1_sel, src2_sel
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_dest, id_mem_r_en,
        input  br_taken,
        output stall, flush, src1_sel, src2_sel
    );

endinterface

// File: rtl/hazard_slot_cmp.sv
// Compares one source register index against one scoreboard slot.
// A match needs a live producer that writes back to exactly that index.
module hazard_slot_cmp
    import exec_hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  logic             src_en,
    input  slot_t            slot,
    output logic             match
);

    assign match = src_en & slot.valid & slot.wb_en & (slot.dest == src);

endmodule

// File: rtl/exec_hazard_ctrl.sv
// Execute-stage hazard scheduler: shadow scoreboard of EXE/MEM/WB destinations that decides
// issue-with-forwarding, load-use stall or branch kill for the instruction leaving ID.
module exec_hazard_ctrl #(
    parameter bit          FWD_EN = 1'b1,
    parameter int unsigned REG_W  = exec_hazard_ctrl_pkg::REG_W
) (
    input  logic              clk,
    input  logic              rst,
    exec_hazard_ctrl_if.slave bus
);

    import exec_hazard_ctrl_pkg::*;

    slot_t            slot_q [NUM_SLOTS];
    slot_t            exe_d;

    logic [REG_W-1:0] src1;
    logic [REG_W-1:0] src2;
    logic             en1;
    logic             en2;

    logic [NUM_SLOTS-1:0] match1;
    logic [NUM_SLOTS-1:0] match2;

    logic             load_use;
    logic             raw_any;
    logic             hazard;
    logic             stall;
    logic             flush;
    logic             issue;

    logic [1:0]       sel1_d;
    logic [1:0]       sel2_d;
    logic [1:0]       sel1_q;
    logic [1:0]       sel2_q;

    assign src1 = bus.id_src1;
    assign src2 = bus.id_src2;
    assign en1  = bus.id_valid;
    assign en2  = bus.id_valid & bus.id_two_src;

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
        hazard_slot_cmp u_cmp_src1 (
            .src    (src1),
            .src_en (en1),
            .slot   (slot_q[s]),
            .match  (match1[s])
        );

        hazard_slot_cmp u_cmp_src2 (
            .src    (src2),
            .src_en (en2),
            .slot   (slot_q[s]),
            .match  (match2[s])
        );
    end

    always_comb begin
        load_use = 1'b0;
        raw_any  = 1'b0;
        hazard   = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        issue    = 1'b0;
        sel1_d   = SEL_REG;
        sel2_d   = SEL_REG;
        exe_d    = '0;

        load_use = slot_q[SLOT_EXE].is_load & (match1[SLOT_EXE] | match2[SLOT_EXE]);
        raw_any  = (|match1) | (|match2);

        // Without forwarding every producer still in flight must reach the write-first RF.
        if (FWD_EN) begin
            hazard = load_use;
        end else begin
            hazard = raw_any;
        end

        // A taken branch kills the ID instruction, so it overrides any hazard on it.
        flush = ~rst & bus.br_taken;
        stall = ~rst & ~bus.br_taken & hazard;
        issue = bus.id_valid & ~stall & ~bus.br_taken;

        if (issue) begin
            exe_d.valid   = 1'b1;
            exe_d.wb_en   = bus.id_wb_en;
            exe_d.dest    = bus.id_dest;
            exe_d.is_load = bus.id_mem_r_en;
            if (FWD_EN) begin
                sel1_d = fwd_sel(match1[SLOT_EXE], match1[SLOT_MEM]);
                sel2_d = fwd_sel(match2[SLOT_EXE], match2[SLOT_MEM]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= '0;
            end
            sel1_q <= SEL_REG;
            sel2_q <= SEL_REG;
        end else begin
            slot_q[SLOT_WB]  <= slot_q[SLOT_MEM];
            slot_q[SLOT_MEM] <= slot_q[SLOT_EXE];
            slot_q[SLOT_EXE] <= exe_d;
            sel1_q           <= sel1_d;
            sel2_q           <= sel2_d;
        end
    end

    assign bus.stall    = stall;
    assign bus.flush    = flush;
    assign bus.src1_sel = sel1_q;
    assign bus.src2_sel = sel2_q;

endmodule
